// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU, host) in front of the single-port data memory, with read-data return routing.
// Optional build macro DMEM_ARB_RR_EN swaps fixed priority + starvation guard for 2-way round-robin.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Cpu_req,
    input  logic              Cpu_wr,
    input  logic [ADDR_W-1:0] Cpu_addr,
    input  logic [DATA_W-1:0] Cpu_wdata,
    output logic              Cpu_gnt,
    output logic              Cpu_stall,
    output logic              Cpu_rvalid,
    output logic [DATA_W-1:0] Cpu_rdata,
    input  logic              Host_req,
    input  logic              Host_wr,
    input  logic [ADDR_W-1:0] Host_addr,
    input  logic [DATA_W-1:0] Host_wdata,
    output logic              Host_gnt,
    output logic              Host_rvalid,
    output logic [DATA_W-1:0] Host_rdata,
    output logic [ADDR_W-1:0] M_addr,
    output logic              M_wr,
    output logic [DATA_W-1:0] M_wdata,
    input  logic [DATA_W-1:0] M_rdata
);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    logic              host_win;
    logic              rd_push;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_o;
    logic              ret_cpu;
    logic              ret_host;

`ifdef DMEM_ARB_RR_EN
    owner_e last_owner;

    // Reset to HOST so the very first conflict goes to the CPU.
    always_ff @(posedge Clk) begin
        if (!ResetN)
            last_owner <= OWN_HOST;
        else if (Cpu_gnt)
            last_owner <= OWN_CPU;
        else if (Host_gnt)
            last_owner <= OWN_HOST;
    end

    always_comb host_win = Host_req & (~Cpu_req | (last_owner == OWN_CPU));
`else
    typedef enum logic {
        NORMAL     = 1'b0,
        FORCE_HOST = 1'b1
    } state_e;

    localparam logic [7:0] LIM_M1 = 8'(STARVE_LIM - 1);

    state_e     state;
    logic [7:0] starve_cnt;

    always_comb host_win = Host_req & (~Cpu_req | (state == FORCE_HOST));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (Host_req && !Host_gnt) begin
                        starve_cnt <= starve_cnt + 8'd1;
                        if (starve_cnt == LIM_M1)
                            state <= FORCE_HOST;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                FORCE_HOST: begin
                    // Host either took its forced grant or withdrew; both end the episode.
                    state      <= NORMAL;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= NORMAL;
                    starve_cnt <= '0;
                end
            endcase
        end
    end
`endif

    assign Host_gnt  = host_win;
    assign Cpu_gnt   = Cpu_req & ~host_win;
    assign Cpu_stall = Cpu_req & ~Cpu_gnt;

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        M_addr  = '0;
        M_wr    = 1'b0;
        M_wdata = '0;
        if (Cpu_gnt) begin
            M_addr  = Cpu_addr;
            M_wr    = Cpu_wr;
            M_wdata = Cpu_wdata;
        end else if (Host_gnt) begin
            M_addr  = Host_addr;
            M_wr    = Host_wr;
            M_wdata = Host_wdata;
        end
    end

    assign rd_push = (Cpu_gnt & ~Cpu_wr) | (Host_gnt & ~Host_wr);

    // Tag pipe depth equals the memory read latency, so a tag exits as its data arrives.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            tag_v <= '0;
            tag_o <= '0;
        end else begin
            tag_v[0] <= rd_push;
            tag_o[0] <= Host_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
        end
    end

    assign ret_cpu  = tag_v[RD_LAT-1] & (tag_o[RD_LAT-1] == OWN_CPU);
    assign ret_host = tag_v[RD_LAT-1] & (tag_o[RD_LAT-1] == OWN_HOST);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            Cpu_rvalid  <= 1'b0;
            Host_rvalid <= 1'b0;
            Cpu_rdata   <= '0;
            Host_rdata  <= '0;
        end else begin
            Cpu_rvalid  <= ret_cpu;
            Host_rvalid <= ret_host;
            if (ret_cpu)
                Cpu_rdata <= M_rdata;
            if (ret_host)
                Host_rdata <= M_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model (RD_LAT=1, STARVE_LIM=8).
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        Cpu_req, Cpu_wr;
    logic [7:0]  Cpu_addr;
    logic [15:0] Cpu_wdata;
    logic        Cpu_gnt, Cpu_stall, Cpu_rvalid;
    logic [15:0] Cpu_rdata;
    logic        Host_req, Host_wr;
    logic [7:0]  Host_addr;
    logic [15:0] Host_wdata;
    logic        Host_gnt, Host_rvalid;
    logic [15:0] Host_rdata;
    logic [7:0]  M_addr;
    logic        M_wr;
    logic [15:0] M_wdata;
    logic [15:0] M_rdata;

    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .STARVE_LIM(8)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .Cpu_req(Cpu_req), .Cpu_wr(Cpu_wr), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
        .Cpu_gnt(Cpu_gnt), .Cpu_stall(Cpu_stall), .Cpu_rvalid(Cpu_rvalid), .Cpu_rdata(Cpu_rdata),
        .Host_req(Host_req), .Host_wr(Host_wr), .Host_addr(Host_addr), .Host_wdata(Host_wdata),
        .Host_gnt(Host_gnt), .Host_rvalid(Host_rvalid), .Host_rdata(Host_rdata),
        .M_addr(M_addr), .M_wr(M_wr), .M_wdata(M_wdata), .M_rdata(M_rdata)
    );

    always #5 Clk = ~Clk;

    // Single-port memory, one cycle read latency.
    always @(posedge Clk) begin
        if (M_wr)
            mem[M_addr] <= M_wdata;
        M_rdata <= mem[M_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h12] = 16'hBEEF;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h03] = 16'h3333;
        M_rdata = 16'h0000;

        // 1: reset with both requesting reads
        ResetN = 1'b0;
        Cpu_req = 1'b1;  Cpu_wr = 1'b0;  Cpu_addr = 8'h00;  Cpu_wdata = 16'h0;
        Host_req = 1'b1; Host_wr = 1'b0; Host_addr = 8'h00; Host_wdata = 16'h0;
        tick();
        tick();
        check("rst_cpu_rvalid", 32'(Cpu_rvalid), 32'd0);
        check("rst_host_rvalid", 32'(Host_rvalid), 32'd0);
        check("rst_cpu_rdata", 32'(Cpu_rdata), 32'h0);
        check("rst_host_rdata", 32'(Host_rdata), 32'h0);
        ResetN = 1'b1;
        #1;
        check("rst_cpu_gnt", 32'(Cpu_gnt), 32'd1);
        check("rst_host_gnt", 32'(Host_gnt), 32'd0);
        tick();
        Cpu_req = 1'b0; Host_req = 1'b0;
        tick(); tick(); tick();

        // 2: CPU read of 0x12, data two cycles after grant
        #1;
        check("idle_m_addr", 32'(M_addr), 32'h0);
        Cpu_req = 1'b1; Cpu_wr = 1'b0; Cpu_addr = 8'h12;
        #1;
        check("rd_cpu_gnt", 32'(Cpu_gnt), 32'd1);
        check("rd_cpu_stall", 32'(Cpu_stall), 32'd0);
        check("rd_m_addr", 32'(M_addr), 32'h12);
        check("rd_m_wr", 32'(M_wr), 32'd0);
        tick();
        Cpu_req = 1'b0;
        check("rd_rvalid_early", 32'(Cpu_rvalid), 32'd0);
        tick();
        check("rd_rvalid", 32'(Cpu_rvalid), 32'd1);
        check("rd_rdata", 32'(Cpu_rdata), 32'hBEEF);
        check("rd_host_rvalid", 32'(Host_rvalid), 32'd0);
        tick();
        check("rd_rvalid_pulse", 32'(Cpu_rvalid), 32'd0);
        check("rd_rdata_held", 32'(Cpu_rdata), 32'hBEEF);

        // 3: continuous conflict
        Cpu_req = 1'b1; Cpu_addr = 8'h01; Host_req = 1'b1; Host_addr = 8'h02;
        for (int i = 1; i <= 12; i++) begin
            logic exp_host;
`ifdef DMEM_ARB_RR_EN
            exp_host = (i % 2 == 1);
`else
            exp_host = (i == 9);
`endif
            #1;
            check($sformatf("cf_host_gnt_%0d", i), 32'(Host_gnt), 32'(exp_host));
            check($sformatf("cf_cpu_gnt_%0d", i), 32'(Cpu_gnt), 32'(!exp_host));
            check($sformatf("cf_cpu_stall_%0d", i), 32'(Cpu_stall), 32'(exp_host));
            tick();
        end
        Cpu_req = 1'b0; Host_req = 1'b0;
        tick(); tick(); tick();

`ifndef DMEM_ARB_RR_EN
        // Host withdraws while forced: back to NORMAL with a cleared counter
        Cpu_req = 1'b1; Host_req = 1'b1;
        for (int i = 1; i <= 8; i++) tick();
        Cpu_req = 1'b0; Host_req = 1'b0;
        #1;
        check("fh_drop_m_addr", 32'(M_addr), 32'h0);
        tick();
        Cpu_req = 1'b1; Host_req = 1'b1;
        #1;
        check("fh_drop_cpu_gnt", 32'(Cpu_gnt), 32'd1);
        check("fh_drop_host_gnt", 32'(Host_gnt), 32'd0);
        tick();
        Cpu_req = 1'b0; Host_req = 1'b0;
        tick(); tick(); tick();
`endif

        // 4: host write then CPU read of 0x40
        Host_req = 1'b1; Host_wr = 1'b1; Host_addr = 8'h40; Host_wdata = 16'h00A5;
        #1;
        check("wr_host_gnt", 32'(Host_gnt), 32'd1);
        check("wr_m_wr", 32'(M_wr), 32'd1);
        check("wr_m_addr", 32'(M_addr), 32'h40);
        check("wr_m_wdata", 32'(M_wdata), 32'h00A5);
        tick();
        Host_req = 1'b0; Host_wr = 1'b0;
        Cpu_req = 1'b1; Cpu_wr = 1'b0; Cpu_addr = 8'h40;
        #1;
        check("wr_then_rd_m_wr", 32'(M_wr), 32'd0);
        check("wr_then_rd_gnt", 32'(Cpu_gnt), 32'd1);
        tick();
        Cpu_req = 1'b0;
        check("wr_host_rvalid_a", 32'(Host_rvalid), 32'd0);
        tick();
        check("wr_cpu_rvalid", 32'(Cpu_rvalid), 32'd1);
        check("wr_cpu_rdata", 32'(Cpu_rdata), 32'h00A5);
        check("wr_host_rvalid_b", 32'(Host_rvalid), 32'd0);
        tick();
        check("wr_host_rvalid_c", 32'(Host_rvalid), 32'd0);

        // 5: back-to-back reads CPU 1, host 2, CPU 3
        Cpu_req = 1'b1; Cpu_addr = 8'h01;
        #1;
        check("b2b_a_gnt", 32'(Cpu_gnt), 32'd1);
        tick();
        Cpu_req = 1'b0; Host_req = 1'b1; Host_wr = 1'b0; Host_addr = 8'h02;
        #1;
        check("b2b_b_gnt", 32'(Host_gnt), 32'd1);
        check("b2b_b_m_addr", 32'(M_addr), 32'h02);
        tick();
        Host_req = 1'b0; Cpu_req = 1'b1; Cpu_addr = 8'h03;
        #1;
        check("b2b_c_gnt", 32'(Cpu_gnt), 32'd1);
        check("b2b_ret1_cpu_rvalid", 32'(Cpu_rvalid), 32'd1);
        check("b2b_ret1_cpu_rdata", 32'(Cpu_rdata), 32'h1111);
        check("b2b_ret1_host_rvalid", 32'(Host_rvalid), 32'd0);
        tick();
        Cpu_req = 1'b0;
        check("b2b_ret2_host_rvalid", 32'(Host_rvalid), 32'd1);
        check("b2b_ret2_host_rdata", 32'(Host_rdata), 32'h2222);
        check("b2b_ret2_cpu_rvalid", 32'(Cpu_rvalid), 32'd0);
        check("b2b_ret2_cpu_held", 32'(Cpu_rdata), 32'h1111);
        tick();
        check("b2b_ret3_cpu_rvalid", 32'(Cpu_rvalid), 32'd1);
        check("b2b_ret3_cpu_rdata", 32'(Cpu_rdata), 32'h3333);
        check("b2b_ret3_host_rvalid", 32'(Host_rvalid), 32'd0);
        tick();
        check("b2b_quiet", 32'({Cpu_rvalid, Host_rvalid}), 32'd0);

        // 6: reset the cycle after a CPU read grant drops that read
        Cpu_req = 1'b1; Cpu_addr = 8'h12;
        #1;
        check("mid_rst_gnt", 32'(Cpu_gnt), 32'd1);
        tick();
        Cpu_req = 1'b0; ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        check("mid_rst_rvalid_a", 32'(Cpu_rvalid), 32'd0);
        check("mid_rst_cpu_rdata", 32'(Cpu_rdata), 32'h0);
        check("mid_rst_host_rdata", 32'(Host_rdata), 32'h0);
        tick();
        check("mid_rst_rvalid_b", 32'(Cpu_rvalid), 32'd0);
        tick();
        check("mid_rst_rvalid_c", 32'(Cpu_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
